xalu_nibble_sequencer: RTL and testbench

- Multi-cycle controller that runs one 4-bit ALU slice over a wide operand, one nibble per clock, giving a NIBBLES×4-bit ALU from a single slice instance.
- Sits between the command source and the slice. It latches operands, drives the slice's A/B/function/carry-in pins nibble by nibble, threads the carry between nibbles, and assembles the result and status flags.
- Presents a valid/ready command port and a valid/ready result port.

---
 rtl/xalu_nibble_sequencer.sv | 107 ++++++++++
 tb/tb_xalu_nibble_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/xalu_nibble_sequencer.sv
// xalu_nibble_sequencer: runs a 4-bit ALU slice over a NIBBLES*4-bit operand, one nibble per clock.
// Optional XALU_SEQ_EQU_EN accumulates slice_equ into res_equ; when undefined res_equ is tied 0.
module xalu_nibble_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_carry,
  output logic         res_zero,
  output logic         res_equ,
  output logic         res_err,
  output logic [3:0]   slice_a,
  output logic [3:0]   slice_b,
  output logic [3:0]   slice_f,
  output logic         slice_ci_right,
  output logic         slice_ci_left,
  input  logic [3:0]   slice_d,
  input  logic         slice_co_left,
  input  logic         slice_co_right,
  input  logic         slice_zero,
  input  logic         slice_equ
);
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SHR = 4'd6, OP_SHL = 4'd7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_sh, b_sh, res;
  logic [3:0] f;
  logic [CW-1:0] cnt;
  logic carry, zero_acc, err, msb;
  assign msb = f == OP_SHR;
  assign cmd_ready = state == IDLE;
  assign res_valid = state == DONE;
  assign res_data = res;
  assign res_carry = carry;
  assign res_zero = zero_acc;
  assign res_err = err;
  assign slice_a = msb ? a_sh[W-1 -: 4] : a_sh[3:0];
  assign slice_b = msb ? b_sh[W-1 -: 4] : b_sh[3:0];
  assign slice_f = f;
  assign slice_ci_right = msb ? 1'b0 : carry;
  assign slice_ci_left = msb ? carry : 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      f <= '0;
      cnt <= '0;
      carry <= 1'b0;
      zero_acc <= 1'b1;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          res <= '0;
          zero_acc <= 1'b1;
          err <= cmd_op[3];
          carry <= cmd_op[3] ? 1'b0 : cmd_cin;
          state <= cmd_op[3] ? DONE : RUN;
          if (!cmd_op[3]) begin
            a_sh <= cmd_a;
            b_sh <= cmd_b;
            f <= cmd_op;
            cnt <= '0;
          end
        end
        RUN: begin
          a_sh <= msb ? a_sh << 4 : a_sh >> 4;
          b_sh <= msb ? b_sh << 4 : b_sh >> 4;
          res <= msb ? {res[W-5:0], slice_d} : {slice_d, res[W-1:4]};
          carry <= (f == OP_ADD || f == OP_SHL) ? slice_co_left : msb ? slice_co_right : 1'b0;
          zero_acc <= zero_acc & slice_zero;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef XALU_SEQ_EQU_EN
  logic equ_acc;
  assign res_equ = equ_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) equ_acc <= 1'b0;
    else if (state == IDLE && cmd_valid) equ_acc <= !cmd_op[3];
    else if (state == RUN) equ_acc <= equ_acc & slice_equ;
  end
`else
  logic unused_equ;
  assign unused_equ = slice_equ;
  assign res_equ = 1'b0;
`endif
endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// tb_xalu_nibble_sequencer: directed vector table plus stall, reset and illegal-op sequences.
module tb_xalu_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_cin = 0;
  logic [3:0] cmd_op = 0;
  logic [W-1:0] cmd_a = 0, cmd_b = 0;
  logic res_valid, res_ready = 0, res_carry, res_zero, res_equ, res_err;
  logic [W-1:0] res_data;
  logic [3:0] slice_a, slice_b, slice_f, slice_d;
  logic slice_ci_right, slice_ci_left, slice_co_left, slice_co_right, slice_zero, slice_equ;
  int checks = 0, errors = 0;

  xalu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero), .res_equ(res_equ),
    .res_err(res_err), .slice_a(slice_a), .slice_b(slice_b), .slice_f(slice_f),
    .slice_ci_right(slice_ci_right), .slice_ci_left(slice_ci_left), .slice_d(slice_d),
    .slice_co_left(slice_co_left), .slice_co_right(slice_co_right), .slice_zero(slice_zero),
    .slice_equ(slice_equ));

  always #5 clk = ~clk;

  // Behavioural 4-bit slice the sequencer drives.
  logic [4:0] sum;
  always_comb begin
    sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_ci_right};
    slice_d = 4'h0;
    slice_co_left = 1'b0;
    slice_co_right = 1'b0;
    case (slice_f)
      4'd0: {slice_co_left, slice_d} = sum;
      4'd1: slice_d = slice_a & slice_b;
      4'd2: slice_d = slice_a | slice_b;
      4'd3: slice_d = slice_a ^ slice_b;
      4'd4: slice_d = slice_a;
      4'd5: slice_d = slice_b;
      4'd6: begin slice_d = {slice_ci_left, slice_a[3:1]}; slice_co_right = slice_a[0]; end
      4'd7: begin slice_d = {slice_a[2:0], slice_ci_right}; slice_co_left = slice_a[3]; end
      default: slice_d = 4'h0;
    endcase
    slice_zero = slice_d == 4'h0;
    slice_equ = slice_a == slice_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic cin;
    logic [W-1:0] data;
    logic carry, zero, equ, err;
    int lat;
  } vec_t;

  vec_t vecs[11];
  logic [3:0] last_f;

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic eq;
`ifdef XALU_SEQ_EQU_EN
    eq = v.equ;
`else
    eq = 1'b0;
`endif
    check($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_cin = v.cin; cmd_valid = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      cmd_valid = 0;
    end while (!res_valid && lat < 20);
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d data", idx), res_data, v.data);
    check($sformatf("v%0d carry", idx), res_carry, v.carry);
    check($sformatf("v%0d zero", idx), res_zero, v.zero);
    check($sformatf("v%0d equ", idx), res_equ, eq);
    check($sformatf("v%0d err", idx), res_err, v.err);
    if (!v.op[3]) last_f = v.op;
    check($sformatf("v%0d slice_f", idx), slice_f, last_f);
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;
    last_f = 4'd0;
    //        op     a        b        cin  data     c  z  e  err lat
    vecs[0]  = '{4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 1, 0, 0, 5};
    vecs[1]  = '{4'd6, 16'h8001, 16'h0000, 1'b1, 16'hC000, 1, 0, 0, 0, 5};
    vecs[2]  = '{4'd7, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1, 0, 0, 0, 5};
    vecs[3]  = '{4'd3, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 0, 1, 1, 0, 5};
    vecs[4]  = '{4'd1, 16'h1234, 16'h0FF0, 1'b0, 16'h0230, 0, 0, 0, 0, 5};
    vecs[5]  = '{4'd0, 16'h0003, 16'h0004, 1'b1, 16'h0008, 0, 0, 0, 0, 5};
    vecs[6]  = '{4'd2, 16'h1200, 16'h0034, 1'b1, 16'h1234, 0, 0, 0, 0, 5};
    vecs[7]  = '{4'd5, 16'h1111, 16'hABCD, 1'b0, 16'hABCD, 0, 0, 0, 0, 5};
    vecs[8]  = '{4'd4, 16'h7777, 16'h7777, 1'b1, 16'h7777, 0, 0, 1, 0, 5};
    vecs[9]  = '{4'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 1, 1, 0, 5};
    vecs[10] = '{4'd9, 16'h1234, 16'h1234, 1'b1, 16'h0000, 0, 1, 0, 1, 1};

    #12;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset res_valid", res_valid, 0);
    check("reset res_zero", res_zero, 1);
    check("reset res_data", res_data, 0);
    check("reset slice_f", slice_f, 0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Hold the result with res_ready low, then handshake with a new command pending.
    cmd_op = 4'd0; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_cin = 0; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    lat = 1;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("stall latency", lat, 5);
    held = res_data;
    check("stall data", held, 16'h3333);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d valid", i), res_valid, 1);
      check($sformatf("stall%0d data", i), res_data, held);
      check($sformatf("stall%0d cmd_ready", i), cmd_ready, 0);
    end
    cmd_op = 4'd2; cmd_a = 16'h00F0; cmd_b = 16'h0F00; cmd_valid = 1; res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    check("handshake valid", res_valid, 0);
    check("handshake cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    check("next accepted", cmd_ready, 0);
    lat = 1;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("next data", res_data, 16'h0FF0);
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;

    // Asynchronous reset in the middle of RUN discards the partial result.
    cmd_op = 4'd0; cmd_a = 16'hFFFF; cmd_b = 16'hFFFF; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst res_zero", res_zero, 1);
    check("rst res_carry", res_carry, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    last_f = 4'd0;
    run_vec('{4'd0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 0, 0, 0, 0, 5}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
